// File: rtl/kf6845_address_cursor_control_pkg.sv
// kf6845_pkg: shared types and constants for the KF6845 CRTC address/cursor slice.
package kf6845_pkg;
  typedef enum logic [1:0] {STEADY, OFF, BLINK16, BLINK32} blink_mode_t;
  localparam int MA_WIDTH_DEFAULT = 14;
  localparam int RA_WIDTH = 5;
endpackage

// File: rtl/kf6845_address_cursor_control_if.sv
// kf6845_address_cursor_control_if: CPU register write strobes, write data and cursor readback.
interface kf6845_address_cursor_control_if;
  logic [7:0] internal_data_bus;
  logic write_start_address_h;
  logic write_start_address_l;
  logic write_cursor_start;
  logic write_cursor_end;
  logic write_cursor_h;
  logic write_cursor_l;
  logic [7:0] cursor_read_data_h;
  logic [7:0] cursor_read_data_l;
  modport master (
    output internal_data_bus, write_start_address_h, write_start_address_l,
           write_cursor_start, write_cursor_end, write_cursor_h, write_cursor_l,
    input  cursor_read_data_h, cursor_read_data_l
  );
  modport slave (
    input  internal_data_bus, write_start_address_h, write_start_address_l,
           write_cursor_start, write_cursor_end, write_cursor_h, write_cursor_l,
    output cursor_read_data_h, cursor_read_data_l
  );
endinterface

// File: rtl/kf6845_address_cursor_control_cursor_blink.sv
// kf6845_cursor_blink: field counter and cursor blink gating by blink mode.
module kf6845_cursor_blink
  import kf6845_pkg::*;
(
  input  logic        clock,
  input  logic        reset,
  input  logic        ce,
  input  logic        V_total,
  input  blink_mode_t mode,
  output logic        blink_on
);
  logic [4:0] field_counter_q, field_counter_d;
  always_comb begin
    field_counter_d = (ce & V_total) ? field_counter_q + 5'd1 : field_counter_q;
    blink_on = mode == STEADY  ? 1'b1 :
               mode == BLINK16 ? field_counter_q[3] :
               mode == BLINK32 ? field_counter_q[4] : 1'b0;
  end
  always_ff @(posedge clock or posedge reset)
    if (reset) field_counter_q <= '0;
    else       field_counter_q <= field_counter_d;
endmodule

// File: rtl/kf6845_address_cursor_control.sv
// kf6845_address_cursor_control: refresh address generator with display-enable and cursor video.
module kf6845_address_cursor_control
  import kf6845_pkg::*;
#(
  parameter int MA_WIDTH = MA_WIDTH_DEFAULT
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  video_clock_enable,
  kf6845_address_cursor_control_if.slave cpu,
  input  logic                  H_Display,
  input  logic                  H_Display_End,
  input  logic                  Horizontal,
  input  logic                  V_total,
  input  logic                  Scanline_End,
  input  logic                  V_Display,
  input  logic [RA_WIDTH-1:0]   RA,
  output logic [MA_WIDTH-1:0]   MA,
  output logic                  DISPEN,
  output logic                  CURSOR
);
  logic [MA_WIDTH-1:0] start_address_q, cursor_address_q;
  logic [MA_WIDTH-1:0] ma_q, ma_d, row_start_q, row_start_d, row_end_latch_q;
  logic [RA_WIDTH-1:0] cursor_start_q, cursor_end_q;
  blink_mode_t         mode_q;
  logic                dispen_q, cursor_q, blink_on, ce, de, cursor_d;
  kf6845_cursor_blink u_blink (
    .clock   (clock),
    .reset   (reset),
    .ce      (ce),
    .V_total (V_total),
    .mode    (mode_q),
    .blink_on(blink_on)
  );
  // A new row start is only taken at the end of a scan line; otherwise the line repeats.
  always_comb begin
    ce = video_clock_enable;
    de = H_Display & V_Display;
    row_start_d = !Horizontal ? row_start_q :
                  V_total     ? start_address_q :
                  Scanline_End ? row_end_latch_q : row_start_q;
    ma_d = Horizontal ? row_start_d : ma_q + 1'b1;
    cursor_d = de & (ma_q == cursor_address_q) & (RA >= cursor_start_q) &
               (RA <= cursor_end_q) & blink_on;
  end
  always_ff @(posedge clock or posedge reset)
    if (reset) begin
      start_address_q  <= '0;
      cursor_address_q <= '0;
      cursor_start_q   <= '0;
      cursor_end_q     <= '0;
      mode_q           <= STEADY;
    end else begin
      if (cpu.write_start_address_h) start_address_q[MA_WIDTH-1:8] <= cpu.internal_data_bus[MA_WIDTH-9:0];
      if (cpu.write_start_address_l) start_address_q[7:0] <= cpu.internal_data_bus;
      if (cpu.write_cursor_h) cursor_address_q[MA_WIDTH-1:8] <= cpu.internal_data_bus[MA_WIDTH-9:0];
      if (cpu.write_cursor_l) cursor_address_q[7:0] <= cpu.internal_data_bus;
      if (cpu.write_cursor_start) begin
        mode_q         <= blink_mode_t'(cpu.internal_data_bus[6:5]);
        cursor_start_q <= cpu.internal_data_bus[4:0];
      end
      if (cpu.write_cursor_end) cursor_end_q <= cpu.internal_data_bus[4:0];
    end
  always_ff @(posedge clock or posedge reset)
    if (reset) begin
      ma_q            <= '0;
      row_start_q     <= '0;
      row_end_latch_q <= '0;
      dispen_q        <= 1'b0;
      cursor_q        <= 1'b0;
    end else if (ce) begin
      ma_q        <= ma_d;
      row_start_q <= row_start_d;
      dispen_q    <= de;
      cursor_q    <= cursor_d;
      if (H_Display_End) row_end_latch_q <= ma_q;
    end
  assign MA     = ma_q;
  assign DISPEN = dispen_q;
  assign CURSOR = cursor_q;
  assign cpu.cursor_read_data_h = 8'(cursor_address_q[MA_WIDTH-1:8]);
  assign cpu.cursor_read_data_l = cursor_address_q[7:0];
endmodule

// File: tb/tb_kf6845_address_cursor_control.sv
// tb_kf6845_address_cursor_control: directed checks of MA sequencing, cursor, blink and reset.
module tb_kf6845_address_cursor_control;
  logic clock = 1'b0, reset = 1'b1, video_clock_enable = 1'b0;
  logic H_Display = 0, H_Display_End = 0, Horizontal = 0, V_total = 0, Scanline_End = 0, V_Display = 0;
  logic [4:0] RA = '0;
  logic [13:0] MA;
  logic DISPEN, CURSOR;
  int total = 0, bad = 0;
  kf6845_address_cursor_control_if bus();
  kf6845_address_cursor_control #(.MA_WIDTH(14)) dut (
    .clock(clock), .reset(reset), .video_clock_enable(video_clock_enable), .cpu(bus),
    .H_Display(H_Display), .H_Display_End(H_Display_End), .Horizontal(Horizontal),
    .V_total(V_total), .Scanline_End(Scanline_End), .V_Display(V_Display), .RA(RA),
    .MA(MA), .DISPEN(DISPEN), .CURSOR(CURSOR)
  );
  always #5 clock = ~clock;

  task automatic clear_strobes();
    bus.write_start_address_h = 0; bus.write_start_address_l = 0;
    bus.write_cursor_start = 0; bus.write_cursor_end = 0;
    bus.write_cursor_h = 0; bus.write_cursor_l = 0;
  endtask

  task automatic do_reset();
    clear_strobes(); bus.internal_data_bus = '0;
    video_clock_enable = 0; Horizontal = 0; V_total = 0; Scanline_End = 0;
    H_Display = 0; H_Display_End = 0;
    reset = 1; @(posedge clock); #1; reset = 0;
  endtask

  task automatic wr(input int r, input logic [7:0] d);
    video_clock_enable = 0;
    bus.internal_data_bus = d;
    case (r)
      10: bus.write_cursor_start = 1;
      11: bus.write_cursor_end = 1;
      12: bus.write_start_address_h = 1;
      13: bus.write_start_address_l = 1;
      14: bus.write_cursor_h = 1;
      default: bus.write_cursor_l = 1;
    endcase
    @(posedge clock); #1;
    clear_strobes();
  endtask

  task automatic step(input logic hd, input logic hde, input logic hz, input logic vt, input logic se);
    H_Display = hd; H_Display_End = hde; Horizontal = hz; V_total = vt; Scanline_End = se;
    video_clock_enable = 1;
    @(posedge clock); #1;
    video_clock_enable = 0; Horizontal = 0; V_total = 0; Scanline_End = 0; H_Display_End = 0;
  endtask

  // 50 characters per line, 40 displayed; CURSOR seen at char h describes the MA of char h-1.
  task automatic run_line(input bit vt, input bit se, output logic [13:0] first_ma,
                          output int hits, output logic [13:0] hit_ma);
    logic [13:0] prev;
    hits = 0; hit_ma = '0; prev = '0; first_ma = '0;
    for (int h = 0; h < 50; h++) begin
      H_Display = h < 40; H_Display_End = h == 40; Horizontal = h == 49;
      V_total = vt && h == 49; Scanline_End = se && h == 49; video_clock_enable = 1;
      if (h == 0) first_ma = MA;
      if (h > 0 && CURSOR) begin hits++; hit_ma = prev; end
      prev = MA;
      @(posedge clock); #1;
    end
    video_clock_enable = 0; Horizontal = 0; V_total = 0; Scanline_End = 0; H_Display = 0; H_Display_End = 0;
  endtask

  task automatic test_reset();
    do_reset();
    total++; if (MA !== 14'h0) begin bad++; $display("FAIL reset_ma got=%h exp=0", MA); end
    total++; if (DISPEN !== 1'b0) begin bad++; $display("FAIL reset_dispen got=%b exp=0", DISPEN); end
    total++; if (CURSOR !== 1'b0) begin bad++; $display("FAIL reset_cursor got=%b exp=0", CURSOR); end
    total++; if (bus.cursor_read_data_h !== 8'h00) begin bad++; $display("FAIL reset_rd_h got=%h exp=00", bus.cursor_read_data_h); end
    total++; if (bus.cursor_read_data_l !== 8'h00) begin bad++; $display("FAIL reset_rd_l got=%h exp=00", bus.cursor_read_data_l); end
  endtask

  task automatic test_address();
    logic [13:0] fm, hm; int hits;
    do_reset();
    wr(12, 8'h01); wr(13, 8'h00);
    V_Display = 1;
    step(0, 0, 1, 1, 0);
    total++; if (MA !== 14'h100) begin bad++; $display("FAIL frame_start got=%h exp=0100", MA); end
    for (int l = 0; l < 8; l++) begin
      RA = 5'(l);
      run_line(0, l == 7, fm, hits, hm);
      total++; if (fm !== 14'h100) begin bad++; $display("FAIL line%0d_start got=%h exp=0100", l, fm); end
    end
    total++; if (MA !== 14'h128) begin bad++; $display("FAIL row1_start got=%h exp=0128", MA); end
    step(1, 0, 0, 0, 0);
    total++; if (DISPEN !== 1'b1) begin bad++; $display("FAIL dispen_on got=%b exp=1", DISPEN); end
    V_Display = 0;
    step(1, 0, 0, 0, 0);
    total++; if (DISPEN !== 1'b0) begin bad++; $display("FAIL dispen_vblank got=%b exp=0", DISPEN); end
  endtask

  task automatic test_wrap();
    logic [13:0] exp_ma [4];
    exp_ma = '{14'h3FFE, 14'h3FFF, 14'h0000, 14'h0001};
    do_reset();
    wr(12, 8'h3F); wr(13, 8'hFE);
    step(0, 0, 1, 1, 0);
    for (int i = 0; i < 4; i++) begin
      total++; if (MA !== exp_ma[i]) begin bad++; $display("FAIL wrap%0d got=%h exp=%h", i, MA, exp_ma[i]); end
      step(0, 0, 0, 0, 0);
    end
  endtask

  task automatic test_cursor();
    logic [13:0] fm, hm; int hits;
    do_reset();
    wr(12, 8'h01); wr(13, 8'h00);
    wr(14, 8'h01); wr(15, 8'h05); wr(10, 8'h02); wr(11, 8'h04);
    total++; if (bus.cursor_read_data_h !== 8'h01) begin bad++; $display("FAIL rd_h got=%h exp=01", bus.cursor_read_data_h); end
    total++; if (bus.cursor_read_data_l !== 8'h05) begin bad++; $display("FAIL rd_l got=%h exp=05", bus.cursor_read_data_l); end
    V_Display = 1;
    step(0, 0, 1, 1, 0);
    for (int r = 0; r < 7; r++) begin
      RA = 5'(r);
      run_line(0, 0, fm, hits, hm);
      total++;
      if (hits !== ((r >= 2 && r <= 4) ? 1 : 0)) begin bad++; $display("FAIL cursor_ra%0d hits got=%0d exp=%0d", r, hits, (r >= 2 && r <= 4) ? 1 : 0); end
      if (r == 3) begin
        total++; if (hm !== 14'h105) begin bad++; $display("FAIL cursor_ma got=%h exp=0105", hm); end
      end
    end
    wr(10, 8'h05); wr(11, 8'h02);
    RA = 5'd3;
    run_line(0, 0, fm, hits, hm);
    total++; if (hits !== 0) begin bad++; $display("FAIL cursor_inverted hits got=%0d exp=0", hits); end
  endtask

  task automatic test_blink();
    logic [13:0] fm, hm; int hits, off_hits;
    do_reset();
    wr(12, 8'h01); wr(13, 8'h00);
    wr(14, 8'h01); wr(15, 8'h05); wr(10, 8'h42); wr(11, 8'h04);
    V_Display = 1; RA = 5'd2;
    step(0, 0, 1, 1, 0);
    for (int f = 1; f < 18; f++) begin
      run_line(1, 0, fm, hits, hm);
      total++;
      if (hits !== ((f >= 8 && f <= 15) ? 1 : 0)) begin bad++; $display("FAIL blink16_field%0d hits got=%0d exp=%0d", f, hits, (f >= 8 && f <= 15) ? 1 : 0); end
    end
    wr(10, 8'h22);
    off_hits = 0;
    for (int f = 18; f < 34; f++) begin
      run_line(1, 0, fm, hits, hm);
      off_hits += hits;
    end
    total++; if (off_hits !== 0) begin bad++; $display("FAIL blink_off hits got=%0d exp=0", off_hits); end
  endtask

  task automatic test_priority();
    do_reset();
    wr(12, 8'h02); wr(13, 8'h00);
    step(0, 0, 1, 1, 0);
    step(1, 1, 0, 0, 0);
    wr(12, 8'h00); wr(13, 8'h50);
    total++; if (MA !== 14'h201) begin bad++; $display("FAIL start_deferred got=%h exp=0201", MA); end
    step(0, 0, 1, 0, 1);
    total++; if (MA !== 14'h200) begin bad++; $display("FAIL scanline_end got=%h exp=0200", MA); end
    step(0, 0, 1, 1, 1);
    total++; if (MA !== 14'h050) begin bad++; $display("FAIL vtotal_wins got=%h exp=0050", MA); end
    step(0, 0, 0, 0, 0);
    step(0, 0, 1, 0, 0);
    total++; if (MA !== 14'h050) begin bad++; $display("FAIL line_repeat got=%h exp=0050", MA); end
  endtask

  task automatic test_midline_reset();
    do_reset();
    wr(12, 8'h01); wr(13, 8'h23);
    wr(14, 8'h00); wr(15, 8'h00); wr(10, 8'h00); wr(11, 8'h04);
    V_Display = 1; RA = 5'd0;
    step(1, 0, 1, 1, 0);
    total++; if (MA !== 14'h123) begin bad++; $display("FAIL pre_reset_ma got=%h exp=0123", MA); end
    total++; if (DISPEN !== 1'b1) begin bad++; $display("FAIL pre_reset_dispen got=%b exp=1", DISPEN); end
    total++; if (CURSOR !== 1'b1) begin bad++; $display("FAIL pre_reset_cursor got=%b exp=1", CURSOR); end
    #1 reset = 1;
    #1;
    total++; if (MA !== 14'h0) begin bad++; $display("FAIL async_reset_ma got=%h exp=0", MA); end
    total++; if (DISPEN !== 1'b0) begin bad++; $display("FAIL async_reset_dispen got=%b exp=0", DISPEN); end
    total++; if (CURSOR !== 1'b0) begin bad++; $display("FAIL async_reset_cursor got=%b exp=0", CURSOR); end
    @(posedge clock); #1; reset = 0; V_Display = 0; H_Display = 0;
    repeat (3) @(posedge clock);
    #1;
    total++; if (MA !== 14'h0) begin bad++; $display("FAIL hold_without_ce got=%h exp=0", MA); end
    step(0, 0, 0, 0, 0);
    total++; if (MA !== 14'h1) begin bad++; $display("FAIL first_ce_after_reset got=%h exp=1", MA); end
  endtask

  initial begin
    clear_strobes(); bus.internal_data_bus = '0;
    test_reset();
    test_address();
    test_wrap();
    test_cursor();
    test_blink();
    test_priority();
    test_midline_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
